// File: rtl/rsa_engine_arbiter.sv
// rsa_engine_arbiter: shares one RSA modular-exponentiation engine between two
// requesters. Grants round-robin, reloads e/n only when the key differs from the
// cached loaded key, sequences the engine command codes and returns the result.
// Optional feature macro: RSA_ARB_TIMEOUT_EN enables an engine-done watchdog of
// TIMEOUT_CYCLES BLANK+WAIT cycles.
// All outputs are registered and describe the current state. req_ready is high
// in the cycle after the IDLE cycle in which the request was sampled.
module rsa_engine_arbiter #(
  parameter int unsigned DATA_W         = 13,
  parameter int unsigned OUT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [2*DATA_W-1:0] req_e,
  input  logic [2*DATA_W-1:0] req_n,
  output logic [1:0]          rsp_valid,
  output logic [OUT_W-1:0]    rsp_data,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   eng_data,
  output logic [2:0]          eng_type,
  input  logic                eng_done,
  input  logic [OUT_W-1:0]    eng_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CMD_SETUP, S_CMD_ISSUE, S_CMD_HOLD, S_BLANK, S_WAIT, S_RESP
  } state_t;

  // Command values equal the engine input_data_type codes.
  typedef enum logic [2:0] {
    C_ENC    = 3'd1,
    C_LOAD_E = 3'd2,
    C_LOAD_N = 3'd3
  } cmd_t;

  state_t            r_state, w_state;
  cmd_t              r_cmd, w_cmd;
  logic              r_ptr, w_ptr;
  logic              r_grant, w_grant;
  logic              r_blank, w_blank;
  logic [DATA_W-1:0] r_data, w_data;
  logic [DATA_W-1:0] r_e, w_e;
  logic [DATA_W-1:0] r_n, w_n;
  logic              r_cache_valid, w_cache_valid;
  logic [DATA_W-1:0] r_cache_e, w_cache_e;
  logic [DATA_W-1:0] r_cache_n, w_cache_n;
  logic [1:0]        r_req_ready, w_req_ready;
  logic [1:0]        r_rsp_valid, w_rsp_valid;
  logic [OUT_W-1:0]  r_rsp_data, w_rsp_data;
  logic              r_rsp_err, w_rsp_err;
  logic [DATA_W-1:0] r_eng_data, w_eng_data;
  logic [2:0]        r_eng_type, w_eng_type;
  logic              w_range_err;
  logic              w_key_hit;
  logic [1:0]        w_grant_1h;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt, w_to_cnt;
  logic            w_to_expire;
  // Current BLANK/WAIT cycle is the TIMEOUT_CYCLES-th since the encrypt issue.
  assign w_to_expire = (32'(r_to_cnt) + 32'd1) >= TIMEOUT_CYCLES;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign eng_data  = r_eng_data;
  assign eng_type  = r_eng_type;

  assign w_range_err = (r_data >= r_n) || (r_n < DATA_W'(2));
  assign w_key_hit   = r_cache_valid && (r_cache_e == r_e) && (r_cache_n == r_n);
  assign w_grant_1h  = r_grant ? 2'b10 : 2'b01;

  // Next-state and next-output decode.
  always_comb begin
    w_state       = r_state;
    w_cmd         = r_cmd;
    w_ptr         = r_ptr;
    w_grant       = r_grant;
    w_blank       = r_blank;
    w_data        = r_data;
    w_e           = r_e;
    w_n           = r_n;
    w_cache_valid = r_cache_valid;
    w_cache_e     = r_cache_e;
    w_cache_n     = r_cache_n;
    w_req_ready   = 2'b00;
    w_rsp_valid   = 2'b00;
    w_rsp_data    = r_rsp_data;
    w_rsp_err     = r_rsp_err;
    w_eng_data    = r_eng_data;
    w_eng_type    = 3'd0;
`ifdef RSA_ARB_TIMEOUT_EN
    w_to_cnt      = r_to_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_grant     = req_valid[r_ptr] ? r_ptr : ~r_ptr;
          w_req_ready = w_grant ? 2'b10 : 2'b01;
          w_data      = w_grant ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
          w_e         = w_grant ? req_e[2*DATA_W-1:DATA_W]    : req_e[DATA_W-1:0];
          w_n         = w_grant ? req_n[2*DATA_W-1:DATA_W]    : req_n[DATA_W-1:0];
          w_ptr       = ~w_grant;
          w_state     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_range_err) begin
          w_rsp_valid = w_grant_1h;
          w_rsp_err   = 1'b1;
          w_rsp_data  = '0;
          w_state     = S_RESP;
        end else if (w_key_hit) begin
          w_cmd      = C_ENC;
          w_eng_data = r_data;
          w_state    = S_CMD_SETUP;
        end else begin
          // Engine key is about to change: cache is stale until load-n completes.
          w_cache_valid = 1'b0;
          w_cmd         = C_LOAD_E;
          w_eng_data    = r_e;
          w_state       = S_CMD_SETUP;
        end
      end
      S_CMD_SETUP: begin
        w_eng_type = r_cmd;
        w_state    = S_CMD_ISSUE;
      end
      S_CMD_ISSUE: begin
        if (r_cmd == C_ENC) begin
          w_blank = 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
          w_to_cnt = '0;
`endif
          w_state = S_BLANK;
        end else begin
          w_state = S_CMD_HOLD;
        end
      end
      S_CMD_HOLD: begin
        if (r_cmd == C_LOAD_E) begin
          w_cmd      = C_LOAD_N;
          w_eng_data = r_n;
        end else begin
          w_cache_valid = 1'b1;
          w_cache_e     = r_e;
          w_cache_n     = r_n;
          w_cmd         = C_ENC;
          w_eng_data    = r_data;
        end
        w_state = S_CMD_SETUP;
      end
      S_BLANK: begin
        // eng_done may still be high from the previous job here.
`ifdef RSA_ARB_TIMEOUT_EN
        w_to_cnt = r_to_cnt + TO_W'(1);
`endif
        if (r_blank) begin
          w_state = S_WAIT;
        end else begin
          w_blank = 1'b1;
        end
      end
      S_WAIT: begin
`ifdef RSA_ARB_TIMEOUT_EN
        w_to_cnt = r_to_cnt + TO_W'(1);
`endif
        if (eng_done) begin
          w_rsp_valid = w_grant_1h;
          w_rsp_err   = 1'b0;
          w_rsp_data  = eng_result;
          w_state     = S_RESP;
        end
`ifdef RSA_ARB_TIMEOUT_EN
        else if (w_to_expire) begin
          w_rsp_valid   = w_grant_1h;
          w_rsp_err     = 1'b1;
          w_rsp_data    = '1;
          w_cache_valid = 1'b0;
          w_state       = S_RESP;
        end
`endif
      end
      S_RESP: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset drops any in-flight job.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cmd         <= C_ENC;
      r_ptr         <= 1'b0;
      r_grant       <= 1'b0;
      r_blank       <= 1'b0;
      r_data        <= '0;
      r_e           <= '0;
      r_n           <= '0;
      r_cache_valid <= 1'b0;
      r_cache_e     <= '0;
      r_cache_n     <= '0;
      r_req_ready   <= 2'b00;
      r_rsp_valid   <= 2'b00;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_eng_data    <= '0;
      r_eng_type    <= 3'd0;
`ifdef RSA_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_state       <= w_state;
      r_cmd         <= w_cmd;
      r_ptr         <= w_ptr;
      r_grant       <= w_grant;
      r_blank       <= w_blank;
      r_data        <= w_data;
      r_e           <= w_e;
      r_n           <= w_n;
      r_cache_valid <= w_cache_valid;
      r_cache_e     <= w_cache_e;
      r_cache_n     <= w_cache_n;
      r_req_ready   <= w_req_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_data    <= w_rsp_data;
      r_rsp_err     <= w_rsp_err;
      r_eng_data    <= w_eng_data;
      r_eng_type    <= w_eng_type;
`ifdef RSA_ARB_TIMEOUT_EN
      r_to_cnt      <= w_to_cnt;
`endif
    end
  end

endmodule

// File: doc/rsa_engine_arbiter.md
# rsa_engine_arbiter

Scheduler that shares the single RSA modular-exponentiation engine (the controller/datapath pair) between two independent requesters. Each request carries a plaintext value and its own key pair (e, n). The arbiter grants round-robin and reloads e/n into the engine only when they differ from the cached loaded key. It then sequences the engine's `input_data_type` command codes and returns the encoded result to the winning requester.

## Interface
Parameters:
- `DATA_W`, 13: width of data, e and n (engine `data` width).
- `OUT_W`, 16: width of engine result.
- `TIMEOUT_CYCLES`, 4096: watchdog limit; used only with `RSA_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  2  request pending, one bit per requester; bit i belongs to requester i.
- `req_ready`  out  2  one-hot accept pulse.
- `req_data`  in  2×DATA_W  plaintext; requester i occupies slice [i*DATA_W +: DATA_W].
- `req_e`  in  2×DATA_W  public exponent, same slicing.
- `req_n`  in  2×DATA_W  modulus, same slicing.
- `rsp_valid`  out  2  one-hot, one-cycle response pulse.
- `rsp_data`  out  OUT_W  result; valid only while `rsp_valid` is nonzero.
- `rsp_err`  out  1  error flag; qualified by `rsp_valid`.
- `eng_data`  out  DATA_W  to engine `data`.
- `eng_type`  out  3  to engine `input_data_type`: 0 idle, 1 encrypt, 2 load e, 3 load n.
- `eng_done`  in  1  from engine `done`.
- `eng_result`  in  OUT_W  from engine `output_data`.

## Operation
- States: IDLE, CHECK, CMD_SETUP, CMD_ISSUE, CMD_HOLD, BLANK, WAIT, RESP.
- IDLE: if any `req_valid`, grant requester `ptr` if valid, else the other. Pulse `req_ready[g]` for that cycle, latch data/e/n, set `ptr` to ~g, go to CHECK. With no request, stay in IDLE.
- CHECK:
  - If data ≥ n or n < 2: go to RESP with `rsp_err`=1, `rsp_data`=0. No engine activity.
  - Else if cache is valid and e and n both match: queue encrypt.
  - Else: queue load-e, then load-n, then encrypt, and invalidate the cache first.
- Each engine command takes three cycles: CMD_SETUP (`eng_data` driven, `eng_type`=0), CMD_ISSUE (`eng_type`=code, exactly one cycle), CMD_HOLD (`eng_type`=0, `eng_data` held).
  - After load-n's HOLD, record cache_e/cache_n and set cache valid.
  - Encrypt skips HOLD and goes to BLANK.
- BLANK: 2 cycles during which `eng_done` is ignored, because the engine's done from the previous job may still be high. Then go to WAIT.
- WAIT: hold `eng_data`. On the first cycle `eng_done`=1, capture `eng_result` and go to RESP.
- RESP: `rsp_valid[g]`=1 for one cycle, then go to IDLE. There is no response backpressure; requesters must accept the pulse.
- `eng_type` is never nonzero outside CMD_ISSUE.
- Width rules: `eng_data` is the latched value unmodified. The comparisons data≥n and n<2 are unsigned DATA_W.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `eng_data`=0, `eng_type`=0. Also `ptr`=0, cache invalid, state IDLE.
- Accept at cycle T. Timeline for a cache hit:
  - T+1: CHECK.
  - T+2: encrypt SETUP.
  - T+3: `eng_type`=1.
  - T+4, T+5: BLANK.
  - First `eng_done` sample at T+6.
  - Done seen at cycle D gives `rsp_valid` at D+1.
- Cache miss adds 6 cycles: `eng_type`=2 at T+3, `eng_type`=3 at T+6, `eng_type`=1 at T+9.
- Range error: `rsp_valid` at T+2.
- Both requesters valid in the same cycle: `ptr` decides the grant. Back-to-back requests alternate.
- A new request can be accepted no earlier than the cycle after RESP.
- `reset` asserted in any state: next cycle all outputs are at reset values and the in-flight job is dropped with no response. The engine is not reset; the next job's BLANK masks its stale done.

## Configuration
- `RSA_ARB_TIMEOUT_EN` defined: a counter clears at CMD_ISSUE of encrypt and counts every BLANK and WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `eng_done`, go to RESP with `rsp_err`=1 and `rsp_data`={OUT_W{1'b1}}, and invalidate the cache.
- Undefined: WAIT waits indefinitely, `TIMEOUT_CYCLES` is unused, and `rsp_err` is raised only by the range check.

## Test plan
- After reset, requester 0 sends data=65, e=17, n=3233 → `eng_type` sequence 2,3,1 with `eng_data` 17,3233,65 → `rsp_valid`=2'b01, `rsp_data`=2790, `rsp_err`=0.
- Requester 0 repeats with data=123 and the same key → only `eng_type`=1 is issued (cache hit) → `rsp_data`=855.
- Both requesters valid in the same cycle after reset: req0 sends data=7 with (e=3, n=15), req1 sends data=65 with (e=17, n=3233).
  - req0 is granted first and gets `rsp_data`=13.
  - req1 then triggers a full reload and gets 2790.
- Requester 1 sends data=3233, n=3233 → `rsp_valid`=2'b10 at T+2, `rsp_err`=1, `rsp_data`=0, and `eng_type` stays 0 throughout.
- With `RSA_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, an engine model holding done=0 → `rsp_err`=1 and `rsp_data`=16'hFFFF 64 cycles after ISSUE; the next request performs a full reload.
- Assert `reset` during WAIT → all outputs are 0 next cycle and no `rsp_valid` appears. A subsequent request with data=7, e=3, n=15 reloads the key and returns 13.
